// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: buffer geometry and capture FSM state encoding.
package la_pkg;

  localparam int LA_ADDR_WIDTH = 17;
  localparam int LA_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_FILL = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POST     = 3'd3,
    ST_DONE     = 3'd4
  } la_state_t;

endpackage

// File: rtl/la_trig_match.sv
// Mask/value trigger compare with optional rising-edge qualification of the match.
module la_trig_match
  import la_pkg::*;
#(
  parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_mask,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic                  i_edge,
  output logic                  o_fire
);

  logic w_match;
  logic r_match_prev;

  assign w_match = (((i_data ^ i_value) & i_mask) == '0);

  // History advances only on real samples so stalls never fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_prev <= 1'b0;
    end else if (i_clear) begin
      r_match_prev <= 1'b0;
    end else if (i_valid) begin
      r_match_prev <= w_match;
    end
  end

  assign o_fire = i_edge ? (w_match & ~r_match_prev) : w_match;

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture controller: circular-buffer writer with pre-trigger depth
// and mask/value trigger, feeding the la_ram write port.
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int ADDR_WIDTH = LA_ADDR_WIDTH,
  parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  probe_valid,
  input  logic [DATA_WIDTH-1:0] probe_data,
  input  logic [DATA_WIDTH-1:0] trig_mask,
  input  logic [DATA_WIDTH-1:0] trig_value,
  input  logic                  trig_edge,
  input  logic [ADDR_WIDTH-1:0] pre_depth,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] trig_addr
);

  la_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_pre_cnt;
  logic [ADDR_WIDTH-1:0] r_pre_depth;
  logic [ADDR_WIDTH-1:0] r_post_cnt;
  logic                  r_busy;
  logic                  r_triggered;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic [ADDR_WIDTH-1:0] r_trig_addr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  logic                  w_capturing;
  logic                  w_sample;
  logic                  w_write;
  logic                  w_arm_go;
  logic                  w_fire;
  logic [ADDR_WIDTH-1:0] w_pre_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_post_init;

  assign w_capturing   = (r_state == ST_PRE_FILL) || (r_state == ST_ARMED) || (r_state == ST_POST);
  assign w_sample      = probe_valid & w_capturing;
  assign w_write       = w_sample & ~abort;
  assign w_arm_go      = arm & ~abort & ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pre_cnt_inc = r_pre_cnt + 1'b1;
  // All-ones is DEPTH-1: post samples left after the trigger sample.
  assign w_post_init   = {ADDR_WIDTH{1'b1}} - r_pre_depth;

  la_trig_match #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_trig_match (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_arm_go),
    .i_valid(probe_valid),
    .i_data (probe_data),
    .i_mask (trig_mask),
    .i_value(trig_value),
    .i_edge (trig_edge),
    .o_fire (w_fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wptr       <= '0;
      r_pre_cnt    <= '0;
      r_pre_depth  <= '0;
      r_post_cnt   <= '0;
      r_busy       <= 1'b0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
      r_start_addr <= '0;
      r_trig_addr  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= r_wptr;
        r_wr_data <= probe_data;
        r_wptr    <= r_wptr + 1'b1;
      end

      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              r_wptr      <= '0;
              r_pre_cnt   <= '0;
              r_pre_depth <= pre_depth;
              r_triggered <= 1'b0;
              r_done      <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= (pre_depth == '0) ? ST_ARMED : ST_PRE_FILL;
            end
          end
          ST_PRE_FILL: begin
            if (probe_valid) begin
              r_pre_cnt <= w_pre_cnt_inc;
              if (w_pre_cnt_inc == r_pre_depth) begin
                r_state <= ST_ARMED;
              end
            end
          end
          ST_ARMED: begin
            if (probe_valid && w_fire) begin
              r_trig_addr  <= r_wptr;
              r_start_addr <= r_wptr - r_pre_depth;
              r_triggered  <= 1'b1;
              r_post_cnt   <= w_post_init;
              if (w_post_init == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (probe_valid) begin
              r_post_cnt <= r_post_cnt - 1'b1;
              if (r_post_cnt == ADDR_WIDTH'(1)) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_data = r_wr_data;
  assign busy        = r_busy;
  assign triggered   = r_triggered;
  assign done        = r_done;
  assign start_addr  = r_start_addr;
  assign trig_addr   = r_trig_addr;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl at DEPTH=16: scenario table plus abort/reset sequences,
// with a behavioural RAM capturing the write port.
module tb_la_capture_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          arm;
  logic          abort;
  logic          probe_valid;
  logic [DW-1:0] probe_data;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_value;
  logic          trig_edge;
  logic [AW-1:0] pre_depth;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] trig_addr;

  la_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .probe_valid(probe_valid),
    .probe_data (probe_data),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_edge  (trig_edge),
    .pre_depth  (pre_depth),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .start_addr (start_addr),
    .trig_addr  (trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural la_ram plus write accounting.
  logic [DW-1:0] mem [DEPTH];
  int            n_wr   = 0;
  int            bad_wr = 0;
  logic          v_edge = 1'b0;

  always @(posedge clk) v_edge <= probe_valid;
  always @(negedge clk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
      n_wr   <= n_wr + 1;
      if (!v_edge) bad_wr <= bad_wr + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d);
    probe_valid = v;
    probe_data  = d;
    @(posedge clk);
    #1;
  endtask

  // mode 0: counting samples, sval substituted at m1/m2; mode 1: constant value, 00 at m1
  typedef struct {
    int          pre;
    logic [7:0]  mask;
    logic [7:0]  value;
    logic        edg;
    int          mode;
    int          m1;
    int          m2;
    logic [7:0]  sval;
    bit          gate;
    int          exp_trig;
    int          exp_start;
    int          exp_writes;
  } scen_t;

  function automatic logic [7:0] data_of(input scen_t s, input int i);
    if (s.mode == 0) return (i == s.m1 || i == s.m2) ? s.sval : 8'(i);
    return (i == s.m1) ? 8'h00 : s.value;
  endfunction

  scen_t scen [6];

  task automatic run_scenario(input int idx, input scen_t s);
    int base, bad_base, si, cyc, last;
    logic v;
    string tag;
    tag        = $sformatf("s%0d", idx);
    trig_mask  = s.mask;
    trig_value = s.value;
    trig_edge  = s.edg;
    pre_depth  = AW'(s.pre);
    probe_valid = 1'b0;
    base     = n_wr;
    bad_base = bad_wr;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    check({tag, " busy after arm"}, int'(busy), 1);
    si = 0;
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      v = !(s.gate && si > s.m1 && (cyc % 3) != 0);
      step(v, data_of(s, si));
      if (v) si++;
    end
    probe_valid = 1'b0;
    check({tag, " done reached"}, int'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " trig_addr"}, int'(trig_addr), s.exp_trig);
    check({tag, " start_addr"}, int'(start_addr), s.exp_start);
    check({tag, " writes"}, n_wr - base, s.exp_writes);
    check({tag, " writes on invalid cycles"}, bad_wr - bad_base, 0);
    check({tag, " busy/triggered/done"}, int'({busy, triggered, done}), 3);
    last = s.exp_writes - 1;
    for (int k = 0; k < DEPTH; k++)
      check($sformatf("%s ram[%0d]", tag, (s.exp_start + k) % DEPTH),
            int'(mem[(s.exp_start + k) % DEPTH]), int'(data_of(s, last - (DEPTH - 1) + k)));
  endtask

  initial begin
    int base;
    scen[0] = '{pre:4,  mask:8'hFF, value:8'hA5, edg:1'b0, mode:0, m1:9,  m2:9,  sval:8'hA5, gate:1'b0, exp_trig:9,  exp_start:5, exp_writes:21};
    scen[1] = '{pre:0,  mask:8'h00, value:8'h00, edg:1'b0, mode:0, m1:-1, m2:-1, sval:8'h00, gate:1'b0, exp_trig:0,  exp_start:0, exp_writes:16};
    scen[2] = '{pre:2,  mask:8'hFF, value:8'h3C, edg:1'b1, mode:1, m1:5,  m2:5,  sval:8'h00, gate:1'b0, exp_trig:6,  exp_start:4, exp_writes:20};
    scen[3] = '{pre:6,  mask:8'hFF, value:8'h77, edg:1'b0, mode:0, m1:2,  m2:14, sval:8'h77, gate:1'b0, exp_trig:14, exp_start:8, exp_writes:24};
    scen[4] = '{pre:4,  mask:8'hFF, value:8'hA5, edg:1'b0, mode:0, m1:9,  m2:9,  sval:8'hA5, gate:1'b1, exp_trig:9,  exp_start:5, exp_writes:21};
    scen[5] = '{pre:15, mask:8'hFF, value:8'h20, edg:1'b0, mode:0, m1:20, m2:20, sval:8'h20, gate:1'b0, exp_trig:4,  exp_start:5, exp_writes:21};

    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; probe_valid = 1'b0; probe_data = '0;
    trig_mask = '0; trig_value = '0; trig_edge = 1'b0; pre_depth = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset busy/triggered/done/wr_en", int'({busy, triggered, done, ram_wr_en}), 0);
    check("reset trig_addr", int'(trig_addr), 0);
    check("reset start_addr", int'(start_addr), 0);

    for (int i = 0; i < 6; i++) run_scenario(i, scen[i]);

    // arm+abort together from DONE: abort wins, trigger info is retained
    arm = 1'b1; abort = 1'b1;
    step(1'b0, 8'h00);
    arm = 1'b0; abort = 1'b0;
    check("arm+abort busy/done", int'({busy, done}), 0);
    check("arm+abort triggered kept", int'(triggered), 1);
    base = n_wr;
    repeat (4) step(1'b1, 8'h55);
    check("arm+abort no writes", n_wr - base, 0);

    // abort in POST with a valid sample in the abort cycle
    trig_mask = 8'hFF; trig_value = 8'hA5; trig_edge = 1'b0; pre_depth = AW'(4);
    base = n_wr;
    arm = 1'b1;
    step(1'b0, 8'h00);
    arm = 1'b0;
    for (int i = 0; i < 13; i++) step(1'b1, (i == 9) ? 8'hA5 : 8'(i));
    abort = 1'b1;
    step(1'b1, 8'd13);
    abort = 1'b0;
    check("abort busy/done/wr_en", int'({busy, done, ram_wr_en}), 0);
    check("abort triggered kept", int'(triggered), 1);
    check("abort trig_addr kept", int'(trig_addr), 9);
    repeat (4) step(1'b1, 8'h66);
    check("abort writes", n_wr - base, 13);

    // asynchronous reset while ARMED
    trig_value = 8'hEE; pre_depth = AW'(2);
    arm = 1'b1;
    step(1'b0, 8'h00);
    arm = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i));
    rst_n = 1'b0;
    #1;
    check("rst busy/triggered/done/wr_en", int'({busy, triggered, done, ram_wr_en}), 0);
    check("rst trig_addr", int'(trig_addr), 0);
    check("rst start_addr", int'(start_addr), 0);
    @(negedge clk) rst_n = 1'b1;
    base = n_wr;
    repeat (3) step(1'b1, 8'hEE);
    check("after rst idle", int'({busy, triggered, done}), 0);
    check("after rst no writes", n_wr - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
